fetch_seq: RTL and testbench

Instruction-fetch sequencer directly upstream of the instruction ROM and control decoder. It owns the program counter and a run/halt state machine started by `req`, and it signals `done`. It applies relative or absolute jumps and freezes on a stall. Its `prog_ctr` output addresses instruction ROM, and its `done` output is the core's completion flag.

---
 rtl/fetch_seq.sv | 65 ++++++
 tb/tb_fetch_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: program-counter sequencer with an IDLE/RUN/DONE run-control FSM
module fetch_seq #(
  parameter int D      = 12,
  parameter int END_PC = 128,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          halt,
  input  logic          absjump_en,
  input  logic          reljump_en,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);
  localparam logic [D-1:0] END_ADDR = D'(END_PC);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d, nxt_pc;
  logic [CW-1:0] cnt_q, cnt_d;
  // candidate PC for a normal RUN cycle; abs beats rel, rel wraps mod 2^D
  always_comb nxt_pc = absjump_en ? target : reljump_en ? pc_q + target : pc_q + D'(1);
  // next state, PC and saturating cycle count
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      if (!stall) begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + CW'(1);
        if (halt) state_d = DONE;
        else begin
          pc_d = nxt_pc;
          if (nxt_pc == END_ADDR) state_d = DONE;
        end
      end
    end else if (req) begin
      state_d = RUN;
      pc_d    = '0;
      cnt_d   = '0;
    end
  end
  // state registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
  assign prog_ctr    = pc_q;
  assign cycle_cnt   = cnt_q;
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign fetch_valid = busy & ~stall;
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized scoreboard bench for two fetch_seq configurations
module tb_fetch_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1, req = 1'b0, stall = 1'b0, halt = 1'b0;
  logic        absjump_en = 1'b0, reljump_en = 1'b0;
  logic [11:0] target = '0;
  logic [11:0] pc_w [2];
  logic        fv_w [2], busy_w [2], done_w [2];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  // instance 0: END_PC=128, 16-bit count; instance 1: END_PC=4095, 4-bit count (saturates)
  fetch_seq #(.D(12), .END_PC(128), .CW(16)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .halt(halt),
    .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
    .prog_ctr(pc_w[0]), .fetch_valid(fv_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .cycle_cnt(cnt0));
  fetch_seq #(.D(12), .END_PC(4095), .CW(4)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .halt(halt),
    .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
    .prog_ctr(pc_w[1]), .fetch_valid(fv_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .cycle_cnt(cnt1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       fv;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0][11:0] pc;
    logic [1:0][15:0] cnt;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;
  int m_mode [2] = '{0, 0};
  int m_pc   [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  int endpc  [2] = '{128, 4095};
  int cmax   [2] = '{65535, 15};

  task automatic chk(input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  // reference model: mode 0=idle, 1=running, 2=finished
  task automatic model_step(input int i, input bit r, input bit rq, input bit st, input bit h,
                            input bit a, input bit rl, input int t);
    int off, np;
    if (r) begin
      m_mode[i] = 0; m_pc[i] = 0; m_cnt[i] = 0;
    end else if (m_mode[i] != 1) begin
      if (rq) begin m_mode[i] = 1; m_pc[i] = 0; m_cnt[i] = 0; end
    end else if (!st) begin
      m_cnt[i] = (m_cnt[i] + 1 > cmax[i]) ? cmax[i] : m_cnt[i] + 1;
      if (h) m_mode[i] = 2;
      else begin
        off = (t >= 2048) ? t - 4096 : t;
        np = a ? t : rl ? (m_pc[i] + off + 4096) % 4096 : (m_pc[i] + 1) % 4096;
        m_pc[i] = np;
        if (np == endpc[i]) m_mode[i] = 2;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit rq, input bit st, input bit h,
                     input bit a, input bit rl, input int t);
    exp_t e;
    @(negedge clk);
    reset = r; req = rq; stall = st; halt = h;
    absjump_en = a; reljump_en = rl; target = 12'(t);
    for (int i = 0; i < 2; i++) begin
      e.fv[i] = (m_mode[i] == 1) && !st;
      model_step(i, r, rq, st, h, a, rl, t);
      e.pc[i]   = 12'(m_pc[i]);
      e.busy[i] = m_mode[i] == 1;
      e.done[i] = m_mode[i] == 2;
      e.cnt[i]  = 16'(m_cnt[i]);
    end
    q.push_back(e);
  endtask

  task automatic plain(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: fetch_valid checked mid-cycle, registered outputs just after the edge
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 2; i++) chk("fetch_valid", i, int'(fv_w[i]), int'(e.fv[i]));
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("prog_ctr", i, int'(pc_w[i]), int'(e.pc[i]));
        chk("busy", i, int'(busy_w[i]), int'(e.busy[i]));
        chk("done", i, int'(done_w[i]), int'(e.done[i]));
        chk("cycle_cnt", i, i == 0 ? int'(cnt0) : int'(cnt1), int'(e.cnt[i]));
      end
    end
  end

  initial begin
    int t;
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    plain(2);
    cyc(0, 1, 0, 0, 0, 0, 0);
    plain(132);
    cyc(0, 1, 0, 0, 0, 0, 0);
    plain(10);
    cyc(0, 0, 0, 0, 1, 0, 40);
    cyc(0, 0, 0, 0, 0, 1, 12'hFFD);
    cyc(0, 0, 0, 0, 1, 1, 5);
    plain(15);
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
    plain(1);
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    plain(5);
    cyc(0, 1, 0, 0, 0, 0, 0);
    plain(6);
    cyc(0, 0, 0, 1, 0, 0, 0);
    plain(5);
    cyc(0, 1, 0, 0, 0, 0, 0);
    plain(50);
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4094);
    plain(3);
    cyc(0, 0, 0, 0, 1, 0, 126);
    plain(2);
    for (int k = 0; k < 3000; k++) begin
      t = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : 4094)
                                      : int'($urandom_range(0, 4095));
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, t);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 0, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
